zxuno_uart_fifo: RTL and testbench

// - ZXUNO-register-mapped 8N1 UART with parametrised RX and TX FIFOs and a built-in baud engine.
// - Next generation of the single-byte register UART: the CPU bursts up to 2**FIFO_AW bytes without polling per byte.
// - Adds sticky overrun/framing error flags.
// - Sits on the ZXUNO register bus beside the other zxuno_addr peripherals; drives the external uart_tx/uart_rx/uart_rts pins.

---
 rtl/zxuno_uart_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_zxuno_uart_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_uart_fifo.sv
// ZXUNO register-mapped 8N1 UART with RX/TX FIFOs and a built-in baud engine.
// Optional RTS flow control is compiled in with `define UART_HW_FLOW_EN.

module zxuno_uart_fifo_buf #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] FULL = (AW+1)'(2**AW);

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so push on full succeeds if popping
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL) || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module zxuno_uart_fifo #(
  parameter logic [7:0]  UARTDATA   = 8'hC6,
  parameter logic [7:0]  UARTSTAT   = 8'hC7,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned CLK_DIV    = 243,
  parameter int unsigned RTS_MARGIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       uart_rts
);
  localparam int unsigned     CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   BIT_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   BIT_MID   = CW'(CLK_DIV / 2 - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(2**FIFO_AW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             wr_sel, rd_data_sel, rd_stat_sel;
  logic             wr_sel_q, rd_data_q, rd_stat_q;
  logic             tx_push, rx_pop, stat_fall;
  logic [7:0]       tx_head, rx_head;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic             tx_empty, tx_full, rx_empty, rx_full, tx_idle;

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_line_q, tx_line_d, tx_pop;

  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_sync1_q, rx_sync2_q, rx_prev_q, rx_push, fe_set, ovr_set;
  logic          overrun_q, framing_q;
  logic [7:0]    rd_val;

  assign wr_sel      = (zxuno_addr == UARTDATA) && zxuno_regwr;
  assign rd_data_sel = (zxuno_addr == UARTDATA) && zxuno_regrd;
  assign rd_stat_sel = (zxuno_addr == UARTSTAT) && zxuno_regrd;
  assign tx_push     = wr_sel && !wr_sel_q;
  assign rx_pop      = rd_data_sel && !rd_data_q;
  assign stat_fall   = rd_stat_q && !rd_stat_sel;

  zxuno_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
    .clk_i(clk), .reset_i(reset), .push_i(tx_push), .din_i(din),
    .pop_i(tx_pop), .head_o(tx_head), .count_o(tx_count)
  );

  zxuno_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
    .clk_i(clk), .reset_i(reset), .push_i(rx_push), .din_i(rx_sh_q),
    .pop_i(rx_pop), .head_o(rx_head), .count_o(rx_count)
  );

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FIFO_FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FIFO_FULL);
  assign tx_idle  = tx_empty && (tx_state_q == S_IDLE);
  assign ovr_set  = rx_push && rx_full && !rx_pop;

  assign rd_val  = rd_data_sel ? (rx_empty ? 8'h00 : rx_head)
                               : {!rx_empty, tx_full, overrun_q, tx_idle, framing_q, 3'b000};
  assign oe_n    = !(rd_data_sel || rd_stat_sel);
  assign dout    = oe_n ? 8'hzz : rd_val;
  assign uart_tx = tx_line_q;

  // STOP end reloads straight into START so consecutive frames have no gap
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_state_d = S_START; tx_line_d = 1'b0;
        end
      end
      S_START: if (tx_cnt_q == BIT_END) begin
        tx_state_d = S_DATA; tx_bit_d = '0; tx_line_d = tx_sh_q[0];
      end
      S_DATA: if (tx_cnt_q == BIT_END) begin
        tx_sh_d = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP; tx_line_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1; tx_line_d = tx_sh_q[1];
        end
      end
      default: if (tx_cnt_q == BIT_END) begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_state_d = S_START; tx_line_d = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == BIT_MID) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      default: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0; rx_push = 1'b1; fe_set = !rx_sync2_q; rx_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel_q <= 1'b0; rd_data_q <= 1'b0; rd_stat_q <= 1'b0;
      tx_state_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; tx_line_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      rx_sync1_q <= 1'b1; rx_sync2_q <= 1'b1; rx_prev_q <= 1'b1;
      overrun_q <= 1'b0; framing_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel; rd_data_q <= rd_data_sel; rd_stat_q <= rd_stat_sel;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d; tx_line_q <= tx_line_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      rx_sync1_q <= uart_rx; rx_sync2_q <= rx_sync1_q; rx_prev_q <= rx_sync2_q;
      overrun_q <= ovr_set || (overrun_q && !stat_fall);
      framing_q <= fe_set  || (framing_q && !stat_fall);
    end
  end

`ifdef UART_HW_FLOW_EN
  logic rts_q;
  always_ff @(posedge clk) begin
    if (reset) rts_q <= 1'b0;
    else       rts_q <= (32'(FIFO_FULL - rx_count) <= RTS_MARGIN);
  end
  assign uart_rts = rts_q;
`else
  assign uart_rts = 1'b0;
`endif
endmodule

// File: tb/tb_zxuno_uart_fifo.sv
// Self-checking bench for zxuno_uart_fifo (CLK_DIV=8, FIFO_AW=2); honours UART_HW_FLOW_EN.
module tb_zxuno_uart_fifo;
  localparam int         CLK_DIV = 8;
  localparam int         FIFO_AW = 2;
  localparam logic [7:0] UDATA   = 8'hC6;
  localparam logic [7:0] USTAT   = 8'hC7;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd, zxuno_regwr;
  logic [7:0] din, dout;
  logic       oe_n, uart_tx, uart_rx, uart_rts;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zxuno_uart_fifo #(.FIFO_AW(FIFO_AW), .CLK_DIV(CLK_DIV), .RTS_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .uart_rts(uart_rts)
  );

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
    repeat (3) @(negedge clk);
    zxuno_regwr = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    zxuno_addr = a; zxuno_regrd = 1'b1;
    #1 v = dout;
    repeat (2) @(negedge clk);
    zxuno_regrd = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int lows;
    reset = 1'b1; zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
    din = 8'h00; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL reset_rts: got %b expected 0", uart_rts); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL idle_oe_n: got %b expected 1", oe_n); end
    zxuno_addr = 8'h3B; zxuno_regrd = 1'b1;
    #1;
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL other_addr_oe_n: got %b expected 1", oe_n); end
    zxuno_regrd = 1'b0;
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL reset_status: got %h expected 10", v); end
    reg_read(UDATA, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL empty_data: got %h expected 00", v); end
    // abort a frame of all-zero data bits
    reg_write(UDATA, 8'h00);
    repeat (20) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b expected 0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_midframe_tx: got %b expected 1", uart_tx); end
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL post_reset_line: got %0d low cycles expected 0", lows); end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL post_reset_status: got %h expected 10", v); end
  endtask

  task automatic tx_writer();
    logic [7:0] v;
    logic [7:0] bytes [5];
    bytes = '{8'h55, 8'hA3, 8'h0F, 8'hFF, 8'h81};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(bytes[i]);
      reg_write(UDATA, bytes[i]);
    end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h40) begin errors++; $display("FAIL tx_full_status: got %h expected 40", v); end
    reg_write(UDATA, 8'h7E);
  endtask

  task automatic tx_monitor(input int nframes);
    int prev_t;
    int w;
    logic [7:0] b, e;
    logic sb;
    prev_t = 0;
    for (int f = 0; f < nframes; f++) begin
      w = 0;
      while (uart_tx !== 1'b0 && w < 400) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w >= 400) begin
        errors++;
        $display("FAIL tx_start_timeout: frame %0d got no start bit expected one within 400 cycles", f);
        return;
      end
      if (f > 0) begin
        checks++;
        if (cyc - prev_t !== 10 * CLK_DIV) begin
          errors++; $display("FAIL tx_frame_spacing: got %0d expected %0d", cyc - prev_t, 10 * CLK_DIV);
        end
      end
      prev_t = cyc;
      repeat (CLK_DIV / 2) @(negedge clk);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_start_bit: got %b expected 0", uart_tx); end
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CLK_DIV) @(negedge clk);
      sb = uart_tx;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (b !== e) begin errors++; $display("FAIL tx_byte: got %h expected %h", b, e); end
      checks++; if (sb !== 1'b1) begin errors++; $display("FAIL tx_stop_bit: got %b expected 1", sb); end
    end
  endtask

  task automatic test_burst_tx();
    logic [7:0] v;
    int lows;
    exp_q.delete();
    fork
      tx_writer();
      tx_monitor(5);
    join
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL tx_dropped_write: got %0d low cycles expected 0", lows); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL tx_missing_frames: got %0d left expected 0", exp_q.size()); end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL tx_idle_status: got %h expected 10", v); end
  endtask

  task automatic test_rx();
    logic [7:0] v, e;
    exp_q.delete();
    exp_q.push_back(8'h41); send_frame(8'h41, 1'b1);
    exp_q.push_back(8'h42); send_frame(8'h42, 1'b1);
    reg_read(USTAT, v);
    checks++; if (v !== 8'h90) begin errors++; $display("FAIL rx_avail_status: got %h expected 90", v); end
    for (int i = 0; i < 2; i++) begin
      reg_read(UDATA, v);
      e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL rx_data: got %h expected %h", v, e); end
    end
    reg_read(UDATA, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rx_empty_data: got %h expected 00", v); end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL rx_empty_status: got %h expected 10", v); end
  endtask

  task automatic test_overrun();
    logic [7:0] v, e;
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1);
    end
    reg_read(USTAT, v);
    checks++; if (v !== 8'hB0) begin errors++; $display("FAIL overrun_set: got %h expected b0", v); end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h90) begin errors++; $display("FAIL overrun_clear: got %h expected 90", v); end
    for (int i = 0; i < 4; i++) begin
      reg_read(UDATA, v);
      e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL overrun_data: got %h expected %h", v, e); end
    end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL overrun_drained: got %h expected 10", v); end
  endtask

  task automatic test_framing();
    logic [7:0] v;
    send_frame(8'h3C, 1'b0);
    reg_read(USTAT, v);
    checks++; if (v !== 8'h98) begin errors++; $display("FAIL framing_set: got %h expected 98", v); end
    reg_read(UDATA, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL framing_data: got %h expected 3c", v); end
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL framing_clear: got %h expected 10", v); end
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    reg_read(USTAT, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL glitch_status: got %h expected 10", v); end
    reg_read(UDATA, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL glitch_data: got %h expected 00", v); end
  endtask

  task automatic test_flow();
    logic [7:0] v;
    send_frame(8'hA1, 1'b1);
`ifdef UART_HW_FLOW_EN
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL rts_one_byte: got %b expected 0", uart_rts); end
`endif
    send_frame(8'hB2, 1'b1);
`ifdef UART_HW_FLOW_EN
    checks++; if (uart_rts !== 1'b1) begin errors++; $display("FAIL rts_assert: got %b expected 1", uart_rts); end
    @(negedge clk);
    zxuno_addr = UDATA; zxuno_regrd = 1'b1;
    #1 v = dout;
    checks++; if (v !== 8'hA1) begin errors++; $display("FAIL flow_data: got %h expected a1", v); end
    @(negedge clk);
    checks++; if (uart_rts !== 1'b1) begin errors++; $display("FAIL rts_latency: got %b expected 1", uart_rts); end
    @(negedge clk);
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL rts_release: got %b expected 0", uart_rts); end
    zxuno_regrd = 1'b0;
    @(negedge clk);
`else
    checks++; if (uart_rts !== 1'b0) begin errors++; $display("FAIL rts_tied: got %b expected 0", uart_rts); end
    reg_read(UDATA, v);
    checks++; if (v !== 8'hA1) begin errors++; $display("FAIL flow_data: got %h expected a1", v); end
`endif
    reg_read(UDATA, v);
    checks++; if (v !== 8'hB2) begin errors++; $display("FAIL flow_data2: got %h expected b2", v); end
  endtask

  initial begin
    test_reset();
    test_burst_tx();
    test_rx();
    test_overrun();
    test_framing();
    test_flow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got stuck, expected completion before 500000");
    $fatal(1);
  end
endmodule
